// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters (IF, MA), the memory port
// arbiter and the single-port memory. The arbiter connects through the
// slave modport; the environment (pipeline plus memory) uses master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // IF stage instruction read
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              stall_if;
    // MA stage load/store
    logic              ma_req;
    logic              ma_we;
    logic [ADDR_W-1:0] ma_addr;
    logic [DATA_W-1:0] ma_wdata;
    logic [DATA_W-1:0] ma_rdata;
    logic              ma_valid;
    logic              stall_ma;
    // Memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata,
        output if_rdata, if_valid, stall_if, ma_rdata, ma_valid, stall_ma,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata,
        input  if_rdata, if_valid, stall_if, ma_rdata, ma_valid, stall_ma,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch
// (IF) and load/store (MA). Each access runs IDLE -> ISSUE -> WAIT -> DONE;
// read data is captured on the last WAIT edge and a one-cycle valid pulse is
// raised in DONE. MA has priority unless it won the previous access and IF
// is waiting, which alternates grants under contention.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic       GNT_IF = 1'b0;
    localparam logic       GNT_MA = 1'b1;
    localparam logic [3:0] LAT    = MEM_LATENCY[3:0];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ma_rdata_q, ma_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              ma_valid_q, ma_valid_d;
    logic              pick_ma_s;

    // MA wins unless it had the last grant and IF is also asking.
    always_comb begin
        pick_ma_s = bus.ma_req & ~((last_grant_q == GNT_MA) & bus.if_req);
    end

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        ma_rdata_d   = ma_rdata_q;
        if_valid_d   = 1'b0;
        ma_valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.if_req | bus.ma_req) begin
                    // Latch the winner's command; mem_addr/mem_wdata double as the latches.
                    grant_d     = pick_ma_s ? GNT_MA : GNT_IF;
                    we_d        = pick_ma_s & bus.ma_we;
                    mem_addr_d  = pick_ma_s ? bus.ma_addr : bus.if_addr;
                    mem_wdata_d = pick_ma_s ? bus.ma_wdata : mem_wdata_q;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_ma_s & bus.ma_we;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Final wait cycle: mem_rdata is valid now, capture it.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                    if (grant_q == GNT_MA) begin
                        ma_valid_d = 1'b1;
                        if (!we_q) begin
                            ma_rdata_d = bus.mem_rdata;
                        end else begin
                            ma_rdata_d = ma_rdata_q;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                // Requests are deliberately not sampled here.
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            grant_q      <= GNT_IF;
            last_grant_q <= GNT_IF;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            if_rdata_q   <= {DATA_W{1'b0}};
            ma_rdata_q   <= {DATA_W{1'b0}};
            if_valid_q   <= 1'b0;
            ma_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            ma_rdata_q   <= ma_rdata_d;
            if_valid_q   <= if_valid_d;
            ma_valid_q   <= ma_valid_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ma_rdata  = ma_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.ma_valid  = ma_valid_q;
    // Stalls stay combinational so the pipeline freezes in the request cycle.
    assign bus.stall_if  = bus.if_req & ~if_valid_q;
    assign bus.stall_ma  = bus.ma_req & ~ma_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Three instances (latency 2, 1, 15)
// share clock and reset. Inputs change 1 ns after the rising edge, outputs are
// checked on the falling edge; "cycle c" of a scenario starts at its c-th edge.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2  ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1  ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b15 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2))  u_l2  (.clk(clk), .rst_n(rst_n), .bus(b2));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1))  u_l1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(15)) u_l15 (.clk(clk), .rst_n(rst_n), .bus(b15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b2.if_req = 1'b0;  b2.if_addr = 32'h0;  b2.ma_req = 1'b0;  b2.ma_we = 1'b0;
        b2.ma_addr = 32'h0;  b2.ma_wdata = 32'h0;  b2.mem_rdata = 32'h0;
        b1.if_req = 1'b0;  b1.if_addr = 32'h0;  b1.ma_req = 1'b0;  b1.ma_we = 1'b0;
        b1.ma_addr = 32'h0;  b1.ma_wdata = 32'h0;  b1.mem_rdata = 32'h0;
        b15.if_req = 1'b0; b15.if_addr = 32'h0; b15.ma_req = 1'b0; b15.ma_we = 1'b0;
        b15.ma_addr = 32'h0; b15.ma_wdata = 32'h0; b15.mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (b2.if_rdata !== 32'h0) begin bad++; $display("FAIL reset.if_rdata got=%h want=0", b2.if_rdata); end
        total++; if (b2.ma_rdata !== 32'h0) begin bad++; $display("FAIL reset.ma_rdata got=%h want=0", b2.ma_rdata); end
        total++; if ({b2.if_valid, b2.ma_valid, b2.mem_en, b2.mem_we} !== 4'b0000) begin
            bad++; $display("FAIL reset.ctrl got=%b want=0000", {b2.if_valid, b2.ma_valid, b2.mem_en, b2.mem_we}); end
        total++; if ({b2.mem_addr, b2.mem_wdata} !== 64'h0) begin
            bad++; $display("FAIL reset.mem_bus got=%h want=0", {b2.mem_addr, b2.mem_wdata}); end
        total++; if ({b2.stall_if, b2.stall_ma} !== 2'b00) begin
            bad++; $display("FAIL reset.stall got=%b want=00", {b2.stall_if, b2.stall_ma}); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_if_read();
        for (int c = 0; c <= 5; c++) begin
            b2.if_req    = (c <= 4);
            b2.if_addr   = 32'h0000_0010;
            b2.mem_rdata = (c == 3) ? 32'hDEAD_BEEF : (32'h0BAD_0000 + 32'(c));
            @(negedge clk);
            total++; if (b2.mem_en !== (c == 1)) begin bad++; $display("FAIL if_read.mem_en c=%0d got=%b want=%b", c, b2.mem_en, (c == 1)); end
            total++; if (b2.mem_we !== 1'b0) begin bad++; $display("FAIL if_read.mem_we c=%0d got=%b want=0", c, b2.mem_we); end
            total++; if (b2.if_valid !== (c == 4)) begin bad++; $display("FAIL if_read.if_valid c=%0d got=%b want=%b", c, b2.if_valid, (c == 4)); end
            total++; if (b2.stall_if !== (c <= 3)) begin bad++; $display("FAIL if_read.stall_if c=%0d got=%b want=%b", c, b2.stall_if, (c <= 3)); end
            if (c == 1) begin
                total++; if (b2.mem_addr !== 32'h10) begin bad++; $display("FAIL if_read.mem_addr got=%h want=00000010", b2.mem_addr); end
            end
            if (c == 4) begin
                total++; if (b2.if_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL if_read.if_rdata got=%h want=deadbeef", b2.if_rdata); end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        for (int c = 0; c <= 10; c++) begin
            b2.ma_req    = (c <= 4);
            b2.ma_we     = 1'b0;
            b2.ma_addr   = 32'h0000_0048;
            b2.if_req    = (c <= 9);
            b2.if_addr   = 32'h0000_0020;
            b2.mem_rdata = 32'h7700_0000 + 32'(c);
            @(negedge clk);
            total++; if (b2.ma_valid !== (c == 4)) begin bad++; $display("FAIL contend.ma_valid c=%0d got=%b want=%b", c, b2.ma_valid, (c == 4)); end
            total++; if (b2.if_valid !== (c == 9)) begin bad++; $display("FAIL contend.if_valid c=%0d got=%b want=%b", c, b2.if_valid, (c == 9)); end
            total++; if (b2.stall_if !== (c <= 8)) begin bad++; $display("FAIL contend.stall_if c=%0d got=%b want=%b", c, b2.stall_if, (c <= 8)); end
            total++; if (b2.stall_ma !== (c <= 3)) begin bad++; $display("FAIL contend.stall_ma c=%0d got=%b want=%b", c, b2.stall_ma, (c <= 3)); end
            total++; if (b2.mem_en !== (c == 1 || c == 6)) begin bad++; $display("FAIL contend.mem_en c=%0d got=%b want=%b", c, b2.mem_en, (c == 1 || c == 6)); end
            if (c == 1) begin
                total++; if (b2.mem_addr !== 32'h48) begin bad++; $display("FAIL contend.ma_addr got=%h want=00000048", b2.mem_addr); end
            end
            if (c == 6) begin
                total++; if (b2.mem_addr !== 32'h20) begin bad++; $display("FAIL contend.if_addr got=%h want=00000020", b2.mem_addr); end
            end
            if (c == 4) begin
                total++; if (b2.ma_rdata !== 32'h7700_0003) begin bad++; $display("FAIL contend.ma_rdata got=%h want=77000003", b2.ma_rdata); end
            end
            if (c == 9) begin
                total++; if (b2.if_rdata !== 32'h7700_0008) begin bad++; $display("FAIL contend.if_rdata got=%h want=77000008", b2.if_rdata); end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_ma_load();
        for (int c = 0; c <= 5; c++) begin
            b2.ma_req    = (c <= 4);
            b2.ma_we     = 1'b0;
            b2.ma_addr   = 32'h0000_0044;
            b2.mem_rdata = 32'h5500_0000 + 32'(c);
            @(negedge clk);
            total++; if (b2.ma_valid !== (c == 4)) begin bad++; $display("FAIL ma_load.ma_valid c=%0d got=%b want=%b", c, b2.ma_valid, (c == 4)); end
            total++; if (b2.mem_we !== 1'b0) begin bad++; $display("FAIL ma_load.mem_we c=%0d got=%b want=0", c, b2.mem_we); end
            if (c == 4) begin
                total++; if (b2.ma_rdata !== 32'h5500_0003) begin bad++; $display("FAIL ma_load.ma_rdata got=%h want=55000003", b2.ma_rdata); end
                total++; if (b2.if_rdata !== 32'h7700_0008) begin bad++; $display("FAIL ma_load.if_rdata_held got=%h want=77000008", b2.if_rdata); end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_ma_store();
        for (int c = 0; c <= 5; c++) begin
            b2.ma_req    = (c <= 4);
            b2.ma_we     = 1'b1;
            b2.ma_addr   = 32'h0000_0040;
            b2.ma_wdata  = 32'h0000_1234;
            b2.mem_rdata = 32'h6600_0000 + 32'(c);
            @(negedge clk);
            total++; if (b2.mem_en !== (c == 1)) begin bad++; $display("FAIL store.mem_en c=%0d got=%b want=%b", c, b2.mem_en, (c == 1)); end
            total++; if (b2.mem_we !== (c == 1)) begin bad++; $display("FAIL store.mem_we c=%0d got=%b want=%b", c, b2.mem_we, (c == 1)); end
            total++; if (b2.ma_valid !== (c == 4)) begin bad++; $display("FAIL store.ma_valid c=%0d got=%b want=%b", c, b2.ma_valid, (c == 4)); end
            total++; if (b2.stall_ma !== (c <= 3)) begin bad++; $display("FAIL store.stall_ma c=%0d got=%b want=%b", c, b2.stall_ma, (c <= 3)); end
            total++; if (b2.ma_rdata !== 32'h5500_0003) begin bad++; $display("FAIL store.ma_rdata c=%0d got=%h want=55000003", c, b2.ma_rdata); end
            if (c == 1) begin
                total++; if ({b2.mem_addr, b2.mem_wdata} !== {32'h40, 32'h1234}) begin
                    bad++; $display("FAIL store.mem_bus got=%h/%h want=00000040/00001234", b2.mem_addr, b2.mem_wdata); end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_addr_change();
        for (int c = 0; c <= 5; c++) begin
            b2.ma_req    = (c <= 4);
            b2.ma_we     = 1'b0;
            b2.ma_addr   = (c == 0) ? 32'h0000_0040 : 32'h0000_0080;
            b2.mem_rdata = 32'h4400_0000 + 32'(c);
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                total++; if (b2.mem_addr !== 32'h40) begin bad++; $display("FAIL addr_change.mem_addr c=%0d got=%h want=00000040", c, b2.mem_addr); end
            end
            if (c == 4) begin
                total++; if (b2.ma_rdata !== 32'h4400_0003) begin bad++; $display("FAIL addr_change.ma_rdata got=%h want=44000003", b2.ma_rdata); end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_latency_sweep();
        for (int c = 0; c <= 18; c++) begin
            b1.if_req     = (c <= 3);
            b1.if_addr    = 32'h0000_0100;
            b1.mem_rdata  = 32'h0100_0000 + 32'(c);
            b15.if_req    = (c <= 17);
            b15.if_addr   = 32'h0000_0F00;
            b15.mem_rdata = 32'h1500_0000 + 32'(c);
            @(negedge clk);
            total++; if (b1.if_valid !== (c == 3)) begin bad++; $display("FAIL lat1.if_valid c=%0d got=%b want=%b", c, b1.if_valid, (c == 3)); end
            total++; if (b15.if_valid !== (c == 17)) begin bad++; $display("FAIL lat15.if_valid c=%0d got=%b want=%b", c, b15.if_valid, (c == 17)); end
            total++; if (b15.mem_en !== (c == 1)) begin bad++; $display("FAIL lat15.mem_en c=%0d got=%b want=%b", c, b15.mem_en, (c == 1)); end
            total++; if (b15.stall_if !== (c <= 16)) begin bad++; $display("FAIL lat15.stall_if c=%0d got=%b want=%b", c, b15.stall_if, (c <= 16)); end
            if (c == 3) begin
                total++; if (b1.if_rdata !== 32'h0100_0002) begin bad++; $display("FAIL lat1.if_rdata got=%h want=01000002", b1.if_rdata); end
            end
            if (c == 17) begin
                total++; if (b15.if_rdata !== 32'h1500_0010) begin bad++; $display("FAIL lat15.if_rdata got=%h want=15000010", b15.if_rdata); end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        for (int c = 0; c <= 8; c++) begin
            b2.if_req    = (c <= 7);
            b2.if_addr   = 32'h0000_0030;
            b2.mem_rdata = 32'h3300_0000 + 32'(c);
            rst_n        = (c != 2);
            @(negedge clk);
            total++; if (b2.if_valid !== (c == 7)) begin bad++; $display("FAIL rst_wait.if_valid c=%0d got=%b want=%b", c, b2.if_valid, (c == 7)); end
            total++; if (b2.mem_en !== (c == 1 || c == 4)) begin bad++; $display("FAIL rst_wait.mem_en c=%0d got=%b want=%b", c, b2.mem_en, (c == 1 || c == 4)); end
            if (c == 2) begin
                total++; if ({b2.mem_addr, b2.if_rdata} !== 64'h0) begin
                    bad++; $display("FAIL rst_wait.cleared got=%h/%h want=0/0", b2.mem_addr, b2.if_rdata); end
            end
            if (c == 4) begin
                total++; if (b2.mem_addr !== 32'h30) begin bad++; $display("FAIL rst_wait.reissue_addr got=%h want=00000030", b2.mem_addr); end
            end
            if (c == 7) begin
                total++; if (b2.if_rdata !== 32'h3300_0006) begin bad++; $display("FAIL rst_wait.if_rdata got=%h want=33000006", b2.if_rdata); end
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_if_read();
        test_contention();
        test_ma_load();
        test_ma_store();
        test_addr_change();
        test_latency_sweep();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency data/instruction memory between the IF stage (instruction reads) and the MA stage (loads and stores).
- The MA request is driven from the control bus: ma_req = isLd | isSt, which are bits [1:0]. ma_we = isSt.
- Sequences each access as issue → wait → respond, and returns read data with a one-cycle valid pulse.
- Generates the per-stage stall signals that freeze the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, cycles from the issue cycle to the cycle in which mem_rdata is valid. Legal range is 1..15.

Ports:
- clk  in  1  sole clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; held high until if_valid.
- if_addr  in  ADDR_W  IF read address.
- if_rdata  out  DATA_W  registered instruction word.
- if_valid  out  1  one-cycle completion pulse for IF.
- stall_if  out  1  freeze IF/ID.
- ma_req  in  1  MA access request; held high until ma_valid.
- ma_we  in  1  1 = store, 0 = load.
- ma_addr  in  ADDR_W  MAR (ALU result).
- ma_wdata  in  DATA_W  MDR (op2).
- ma_rdata  out  DATA_W  registered load result.
- ma_valid  out  1  one-cycle completion pulse for MA; asserted for stores as well.
- stall_ma  out  1  freeze EX/MA and all stages upstream.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, grant=IF, last_grant=IF.
  - All outputs are 0: rdata registers, valid pulses, mem_en, mem_we, mem_addr, mem_wdata.
  - An in-flight access is abandoned. No valid pulse is produced; the requester re-requests after reset.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is sampled high at the edge, latch grant, addr, wdata and we into registers, then go to ISSUE.
  - Arbitration when both request: MA wins, unless last_grant==MA and if_req=1, in which case IF wins. This alternates fairly under contention.
  - With no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en=1. mem_addr, mem_wdata and mem_we come from the latched registers; mem_we=1 only for an MA store.
  - Load counter=MEM_LATENCY, then go to WAIT.
  - In all other states mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last value.
- WAIT (MEM_LATENCY cycles):
  - Decrement the counter each cycle.
  - On the edge where the counter goes 1→0, capture mem_rdata into the granted side's rdata register (loads and IF only), then go to DONE.
- DONE (exactly 1 cycle):
  - Assert the granted side's valid. Update last_grant=grant. Go to IDLE unconditionally.
  - Requests are not sampled in DONE. This prevents a double issue, because the requester drops or changes req on the edge after valid.
- Latency: request sampled in cycle 0 → ISSUE in cycle 1 → WAIT in cycles 2..1+MEM_LATENCY → valid in cycle 2+MEM_LATENCY.
  - Back-to-back accesses from one requester are therefore spaced 3+MEM_LATENCY cycles apart.
- Stalls (combinational):
  - stall_if = if_req & ~(if_valid).
  - stall_ma = ma_req & ~(ma_valid).
  - The non-granted requester stays stalled through the whole transaction.
- rdata registers hold their value until the next completion for the same side.
  - A store does not modify ma_rdata.
- Requester address or data changes after grant are ignored because the values are latched at grant.
- Dropping req mid-transaction does not abort it. The access completes and valid still pulses.
- mem_rdata is ignored in every cycle except the capture edge.

Test Plan:
- Reset then single IF read. MEM_LATENCY=2. if_req=1 with if_addr=0x10 in cycle 0; memory returns 0xDEADBEEF.
  - mem_en=1 with mem_addr=0x10 in cycle 1 only.
  - if_valid=1 with if_rdata=0xDEADBEEF in cycle 4; stall_if=1 in cycles 0–3.
- MA store: ma_req=1, ma_we=1, ma_addr=0x40, ma_wdata=0x1234.
  - Cycle 1: mem_en=1, mem_we=1, mem_addr=0x40, mem_wdata=0x1234.
  - ma_valid pulses in cycle 4; ma_rdata is unchanged.
- Contention: if_req and ma_req both held high from cycle 0.
  - MA is granted first and ma_valid pulses in cycle 4.
  - IF is granted next and if_valid pulses in cycle 9.
  - stall_if stays high in cycles 0–8.
- MEM_LATENCY=1 and MEM_LATENCY=15 sweep: valid appears in cycle 2+MEM_LATENCY, and data is captured from the correct cycle. Drive mem_rdata with different values in each cycle to check.
- Reset mid-WAIT: assert rst_n=0 in cycle 2 of an IF read.
  - Outputs go to 0 immediately; there is no if_valid.
  - After release with if_req still high, a fresh access issues one cycle later.
- Address change after grant: change ma_addr from 0x40 to 0x80 in cycle 1 → mem_addr=0x40 is issued.
